// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a ready/valid byte port and frame_err/overrun pulses.
// Define UART_RX_MAJORITY_EN for 2-of-3 voting around every sample point.
module uart_rx #(
   parameter int CLKS_PER_BIT = 5208
) (
   input  logic       CLOCK_50,
   input  logic       RESET,
   input  logic       UART_RXD,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun
);
   localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2);
   localparam logic [15:0] CPB = 16'(CLKS_PER_BIT);
   localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3, RECOVER = 3'd4;
   logic [1:0] sync;
   logic rxd_s, smp, hit, dlv, ferr;
   logic [2:0] state, bit_idx;
   logic [15:0] cnt;
   logic [7:0] sh;
   assign rxd_s = sync[1];
   always_ff @(posedge CLOCK_50 or posedge RESET)
      if (RESET) sync <= 2'b11;
      else sync <= {sync[0], UART_RXD};
`ifdef UART_RX_MAJORITY_EN
   // Decide one cycle late and reload cnt with 1 so later sample points stay aligned.
   localparam logic [15:0] T_START = HALF, T_BIT = CPB, RELOAD = 16'd1;
   logic [1:0] hist;
   always_ff @(posedge CLOCK_50 or posedge RESET)
      if (RESET) hist <= 2'b11;
      else hist <= {hist[0], rxd_s};
   assign smp = (hist[1] & hist[0]) | (rxd_s & (hist[1] | hist[0]));
`else
   localparam logic [15:0] T_START = HALF - 16'd1, T_BIT = CPB - 16'd1, RELOAD = 16'd0;
   assign smp = rxd_s;
`endif
   assign hit = cnt == ((state == START) ? T_START : T_BIT);
   assign dlv = (state == STOP) && hit && smp;
   assign ferr = (state == STOP) && hit && !smp;
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         state <= IDLE;
         cnt <= 16'd0;
         bit_idx <= 3'd0;
         sh <= 8'd0;
      end else begin
         case (state)
            IDLE:
               if (!rxd_s) begin
                  state <= START;
                  cnt <= 16'd0;
               end
            START:
               if (hit) begin
                  state <= smp ? IDLE : DATA;
                  cnt <= RELOAD;
                  bit_idx <= 3'd0;
               end else cnt <= cnt + 16'd1;
            DATA:
               if (hit) begin
                  sh <= {smp, sh[7:1]};
                  cnt <= RELOAD;
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) state <= STOP;
               end else cnt <= cnt + 16'd1;
            STOP:
               if (hit) begin
                  state <= smp ? IDLE : RECOVER;
                  cnt <= 16'd0;
               end else cnt <= cnt + 16'd1;
            RECOVER:
               if (rxd_s) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         rx_data <= 8'd0;
         rx_valid <= 1'b0;
         frame_err <= 1'b0;
         overrun <= 1'b0;
      end else begin
         if (dlv && (!rx_valid || rx_ready)) begin
            rx_data <= sh;
            rx_valid <= 1'b1;
         end else if (rx_valid && rx_ready) rx_valid <= 1'b0;
         frame_err <= ferr;
         overrun <= dlv && rx_valid && !rx_ready;
      end
   end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven and randomized checks of uart_rx against a frame-level reference model.
module tb_uart_rx;
   localparam int CPB = 16, HALF = CPB / 2;
`ifdef UART_RX_MAJORITY_EN
   localparam bit MAJ = 1'b1;
`else
   localparam bit MAJ = 1'b0;
`endif
   logic CLOCK_50 = 1'b0;
   logic RESET = 1'b1, UART_RXD = 1'b1, rx_ready = 1'b1;
   logic rx_valid, frame_err, overrun;
   logic [7:0] rx_data;
   int total = 0, bad = 0, n_ferr = 0, n_ovr = 0, n_wide = 0, fe_exp = 0;
   bit prev_fe = 1'b0, prev_ov = 1'b0;
   logic [7:0] got[$], expq[$];

   typedef struct {
      logic [7:0] data;
      bit stop;
      int gp;
      logic [7:0] exp_data;
      int exp_valid;
      int exp_ferr;
   } vec_t;
   vec_t tbl[8];

   always #5 CLOCK_50 = ~CLOCK_50;

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .CLOCK_50(CLOCK_50), .RESET(RESET), .UART_RXD(UART_RXD),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .frame_err(frame_err), .overrun(overrun)
   );

   always @(negedge CLOCK_50) if (!RESET) begin
      if (rx_valid && rx_ready) got.push_back(rx_data);
      if (frame_err) n_ferr++;
      if (overrun) n_ovr++;
      if ((frame_err && prev_fe) || (overrun && prev_ov)) n_wide++;
      prev_fe = frame_err;
      prev_ov = overrun;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, want);
      end
   endtask

   task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
      total++;
      if (act < lo || act > hi) begin
         bad++;
         $display("FAIL %s: got %0d want %0d..%0d", nm, act, lo, hi);
      end
   endtask

   task automatic line(input logic v, input int n);
      UART_RXD = v;
      repeat (n) begin
         @(posedge CLOCK_50);
         #1;
      end
   endtask

   task automatic idle(input int n);
      line(1'b1, n);
   endtask

   // Drives len cycles of a frame; gp >= 0 inverts the line for that single cycle.
   task automatic send(input logic [7:0] b, input bit stop, input int gp, input int len);
      for (int c = 0; c < len; c++) begin
         int i;
         logic v;
         i = c / CPB;
         v = (i == 0) ? 1'b0 : (i == 9) ? stop : b[i-1];
         UART_RXD = (c == gp) ? ~v : v;
         @(posedge CLOCK_50);
         #1;
      end
   endtask

   task automatic clr();
      got.delete();
      n_ferr = 0;
      n_ovr = 0;
   endtask

   function automatic logic wav(input logic [7:0] b, input int gp, input int c);
      int i;
      logic v;
      i = c / CPB;
      v = (i >= 1 && i <= 8) ? b[i-1] : (i != 0);
      return (c == gp) ? ~v : v;
   endfunction

   // Byte the receiver should see: line value at mid-bit, or 2-of-3 vote around it.
   function automatic logic [7:0] model(input logic [7:0] b, input int gp);
      logic [7:0] r;
      for (int k = 0; k < 8; k++) begin
         int c;
         logic a, m, z;
         c = (k + 1) * CPB + HALF;
         a = wav(b, gp, c - 1);
         m = wav(b, gp, c);
         z = wav(b, gp, c + 1);
         r[k] = MAJ ? ((a & m) | (a & z) | (m & z)) : m;
      end
      return r;
   endfunction

   function automatic logic [31:0] first();
      return (got.size() > 0) ? {24'd0, got[0]} : 32'hdead;
   endfunction

   initial begin
      tbl[0] = '{8'hA5, 1'b1, -1, 8'hA5, 1, 0};
      tbl[1] = '{8'h00, 1'b1, -1, 8'h00, 1, 0};
      tbl[2] = '{8'hFF, 1'b1, -1, 8'hFF, 1, 0};
      tbl[3] = '{8'h3C, 1'b0, -1, 8'h00, 0, 1};
      tbl[4] = '{8'h81, 1'b1, -1, 8'h81, 1, 0};
      tbl[5] = '{8'h80, 1'b1, -1, 8'h80, 1, 0};
      tbl[6] = '{8'hFF, 1'b1, 56, MAJ ? 8'hFF : 8'hFB, 1, 0};
      tbl[7] = '{8'h5A, 1'b1, 40, MAJ ? 8'h5A : 8'h58, 1, 0};

      repeat (3) @(posedge CLOCK_50);
      #1;
      chk("reset_valid", rx_valid, 0);
      chk("reset_data", rx_data, 0);
      chk("reset_ferr", frame_err, 0);
      chk("reset_ovr", overrun, 0);
      RESET = 1'b0;
      idle(5);

      clr();
      fork
         send(8'hA5, 1'b1, -1, 10 * CPB);
         begin
            int n = 0;
            do begin
               @(posedge CLOCK_50);
               #1;
               n++;
            end while (!rx_valid && n < 400);
            chk_rng("latency", n, 154 + MAJ, 156 + MAJ);
            @(posedge CLOCK_50);
            #1;
            chk("valid_width", rx_valid, 0);
         end
      join
      idle(10);
      chk("basic_count", got.size(), 1);
      chk("basic_data", first(), 8'hA5);
      chk("basic_ferr", n_ferr, 0);

      foreach (tbl[v]) begin
         clr();
         send(tbl[v].data, tbl[v].stop, tbl[v].gp, 10 * CPB);
         idle(3 * CPB);
         chk($sformatf("vec%0d_count", v), got.size(), tbl[v].exp_valid);
         chk($sformatf("vec%0d_data", v), tbl[v].exp_valid ? first() : 32'hdead,
             tbl[v].exp_valid ? {24'd0, tbl[v].exp_data} : 32'hdead);
         chk($sformatf("vec%0d_ferr", v), n_ferr, tbl[v].exp_ferr);
         chk($sformatf("vec%0d_ovr", v), n_ovr, 0);
      end

      clr();
      line(1'b0, 4);
      idle(40);
      line(1'b0, HALF - 1);
      idle(40);
      chk("glitch_count", got.size(), 0);
      chk("glitch_err", n_ferr + n_ovr, 0);
      send(8'h5A, 1'b1, -1, 10 * CPB);
      idle(20);
      chk("post_glitch", first(), 8'h5A);

      clr();
      send(8'h3C, 1'b0, -1, 10 * CPB);
      line(1'b0, 40);
      idle(2 * CPB);
      send(8'h81, 1'b1, -1, 10 * CPB);
      idle(20);
      chk("break_ferr", n_ferr, 1);
      chk("break_count", got.size(), 1);
      chk("break_data", first(), 8'h81);

      rx_ready = 1'b0;
      clr();
      send(8'h11, 1'b1, -1, 10 * CPB);
      send(8'h22, 1'b1, -1, 10 * CPB);
      idle(20);
      chk("ovr_valid", rx_valid, 1);
      chk("ovr_data", rx_data, 8'h11);
      chk("ovr_pulses", n_ovr, 1);
      chk("ovr_ferr", n_ferr, 0);
      rx_ready = 1'b1;
      @(posedge CLOCK_50);
      #1;
      chk("ovr_drain_valid", rx_valid, 0);
      chk("ovr_drain_count", got.size(), 1);
      chk("ovr_drain_data", first(), 8'h11);

      rx_ready = 1'b0;
      clr();
      send(8'h99, 1'b1, -1, 10 * CPB);
      idle(20);
      chk("hold_valid", rx_valid, 1);
      send(8'h77, 1'b1, -1, 4 * CPB + HALF);
      RESET = 1'b1;
      UART_RXD = 1'b1;
      #1;
      chk("midrst_valid", rx_valid, 0);
      chk("midrst_data", rx_data, 0);
      chk("midrst_flags", {frame_err, overrun}, 0);
      repeat (3) @(posedge CLOCK_50);
      #1;
      RESET = 1'b0;
      rx_ready = 1'b1;
      clr();
      idle(2 * CPB);
      send(8'h5A, 1'b1, -1, 10 * CPB);
      idle(20);
      chk("midrst_count", got.size(), 1);
      chk("midrst_next", first(), 8'h5A);

      clr();
      expq.delete();
      fe_exp = 0;
      for (int f = 0; f < 30; f++) begin
         logic [7:0] b;
         bit stop;
         int gp, gap;
         b = 8'($urandom);
         stop = ($urandom_range(0, 7) != 0);
         gp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(CPB, 9 * CPB - 1)) : -1;
         gap = $urandom_range(0, 20) + (stop ? 0 : 4);
         send(b, stop, gp, 10 * CPB);
         if (stop) expq.push_back(model(b, gp));
         else fe_exp++;
         idle(gap);
      end
      idle(40);
      chk("rand_count", got.size(), expq.size());
      foreach (expq[i])
         chk($sformatf("rand_byte%0d", i), (i < got.size()) ? {24'd0, got[i]} : 32'hdead, expq[i]);
      chk("rand_ferr", n_ferr, fe_exp);
      chk("rand_ovr", n_ovr, 0);
      chk("pulse_width", n_wide, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
